mod_74x_multi_counter: RTL and testbench
========================================

MOD_74X_MULTI_COUNTER -- requirements
Module: mod_74x_multi_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, bits per channel (1..16).
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent counter channels (1..8).
REQ-003 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1 (2..2**WIDTH).
REQ-004 SHALL have parameter CASCADE, default 0; 1 chains channel i-1 TC into channel i enable.
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on its falling edge.
REQ-006 SHALL have port CLR_N  input  1  asynchronous active-low reset of all channels.
REQ-007 SHALL have port EN  input  CHANNELS  per-channel count enable, active high.
REQ-008 SHALL have port UP  input  CHANNELS  per-channel direction, 1 = up, 0 = down.
REQ-009 SHALL have port SCLR  input  CHANNELS  per-channel synchronous clear, active high.
REQ-010 SHALL have port LOAD  input  CHANNELS  per-channel synchronous parallel load, active high.
REQ-011 SHALL have port D  input  CHANNELS*WIDTH  load data, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port Q  output  CHANNELS*WIDTH  count values, same packing as D.
REQ-013 SHALL have port TC  output  CHANNELS  per-channel terminal count, combinational.

Function
REQ-014 SHALL, per channel and per falling CLK edge, apply the first true of: SCLR -> 0; LOAD -> D slice; effective enable -> count; else hold.
REQ-015 SHALL define effective enable as EN[i] when CASCADE=0 or i=0, else EN[i] AND TC[i-1].
REQ-016 SHALL, counting up, go from MODULUS-1 (or any value >= MODULUS-1) to 0, otherwise Q+1.
REQ-017 SHALL, counting down, go from 0 to MODULUS-1, otherwise Q-1; a value >= MODULUS loaded then counted down decrements normally.
REQ-018 SHALL load D unmodified, including values >= MODULUS.
REQ-019 SHALL drive TC[i] = effective enable[i] AND (UP[i] ? Q==MODULUS-1 : Q==0), with no register stage.
REQ-020 SHALL take UP, EN, LOAD, SCLR changes into account from the next falling edge; no latency beyond one edge.
REQ-021 SHALL keep channels fully independent when CASCADE=0; SCLR/LOAD on one channel never affects another.
REQ-022 SHALL, with CASCADE=1, advance channel i exactly once per wrap of channel i-1 in the same direction, so N channels form one WIDTH*N-digit counter when MODULUS=2**WIDTH.
REQ-023 SHALL ignore rising CLK edges entirely.

Reset
REQ-024 SHALL force every Q slice to 0 immediately on CLR_N low, regardless of CLK.
REQ-025 SHALL hold Q at 0 while CLR_N low; TC follows REQ-019 from Q=0 (may be high when counting down and enabled).
REQ-026 SHALL resume counting on the first falling CLK edge after CLR_N rises; a reset mid-count discards all channel state.

Structure
REQ-027 SHALL place default WIDTH, CHANNELS, MODULUS constants and the priority ordering (SCLR > LOAD > count) in shared package mod_74x_counter_pkg.
REQ-028 SHALL implement one channel as sub-module mod_74x_counter_chan (counter, TC logic), instantiated CHANNELS times by generate; top holds cascade wiring only.
REQ-029 SHALL contain no latches and no clocks derived from Q (no ripple clocking).

Verification
REQ-030 SHALL cover defaults, all EN=1, UP=1, from reset: Q slices 0,1,..,15,0 on successive falling edges; TC high only while Q=15.
REQ-031 SHALL cover MODULUS=10, UP=0 from 0: Q reads 9,8,..,0,9; TC high only at Q=0.
REQ-032 SHALL cover LOAD=1 with D=0xC on channel 1 and SCLR=1 same edge -> Q1=0; next edge LOAD only -> Q1=0xC; channel 0 counting unaffected.
REQ-033 SHALL cover CASCADE=1, CHANNELS=2, up: after 16 edges {Q1,Q0}=0x10, after 256 edges 0x00; TC[1] high only at 0xFF.
REQ-034 SHALL cover CLR_N pulsed low between edges at Q=7: Q=0 immediately, next falling edge Q=1.
REQ-035 SHALL cover EN=0 for 5 edges at Q=3 -> Q stays 3 and TC stays 0; rising edges never change Q.

Source files
------------

// File: rtl/mod_74x_counter_pkg.sv
// Shared definitions for the multi-channel 74x-style counter.
// Holds the default geometry constants, the per-edge channel action type and
// the helper that fixes the action priority (clear > load > count > hold).
package mod_74x_counter_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_MODULUS  = 16;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_COUNT = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } chan_act_e;

    // Resolve the per-edge action of one channel; earlier tests win.
    function automatic chan_act_e select_action(input logic sclr,
                                                input logic load,
                                                input logic en);
        chan_act_e act;
        if (sclr) begin
            act = ACT_CLEAR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_COUNT;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/mod_74x_counter_chan.sv
// One counter channel: modulo-MODULUS up/down counter with synchronous clear
// and parallel load, state updated on the falling clock edge, plus the
// combinational terminal-count output.
// Ports:
//   clk     - clock, falling edge active
//   clr_n   - asynchronous active-low clear
//   en_eff  - effective count enable (already includes any cascade term)
//   up      - direction, 1 = up, 0 = down
//   sclr    - synchronous clear
//   load    - synchronous parallel load of d
//   d       - load data
//   q       - current count
//   tc      - terminal count (combinational)
module mod_74x_counter_chan
    import mod_74x_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en_eff,
    input  logic             up,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    chan_act_e        act_s;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next-count selection. Counting up wraps from any value at or above
    // MAX_VAL, so out-of-range loaded values return to 0; counting down from
    // such a value simply decrements.
    always_comb begin
        act_s = select_action(sclr, load, en_eff);
        q_d   = q_q;
        case (act_s)
            ACT_CLEAR: q_d = ZERO_VAL;
            ACT_LOAD:  q_d = d;
            ACT_COUNT: begin
                if (up) begin
                    if (q_q >= MAX_VAL) begin
                        q_d = ZERO_VAL;
                    end else begin
                        q_d = q_q + ONE_VAL;
                    end
                end else begin
                    if (q_q == ZERO_VAL) begin
                        q_d = MAX_VAL;
                    end else begin
                        q_d = q_q - ONE_VAL;
                    end
                end
            end
            ACT_HOLD:  q_d = q_q;
            default:   q_d = q_q;
        endcase
    end

    // Count register, falling-edge clocked with asynchronous clear.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= ZERO_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    // Terminal count is deliberately unregistered so a cascaded neighbour
    // sees it in the same cycle.
    assign tc = en_eff & (up ? (q_q == MAX_VAL) : (q_q == ZERO_VAL));

endmodule

// File: rtl/mod_74x_multi_counter.sv
// Multi-channel 74x-style counter: CHANNELS independent (or cascaded)
// modulo-MODULUS up/down counters, all clocked on the falling edge of CLK.
// Ports:
//   CLK   - clock, falling edge active; rising edges are ignored
//   CLR_N - asynchronous active-low clear of every channel
//   EN    - per-channel count enable
//   UP    - per-channel direction, 1 = up
//   SCLR  - per-channel synchronous clear
//   LOAD  - per-channel synchronous parallel load
//   D     - load data, channel i at [i*WIDTH +: WIDTH]
//   Q     - counts, same packing as D
//   TC    - per-channel terminal count (combinational)
module mod_74x_multi_counter
    import mod_74x_counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int CASCADE  = 0
) (
    input  logic                      CLK,
    input  logic                      CLR_N,
    input  logic [CHANNELS-1:0]       EN,
    input  logic [CHANNELS-1:0]       UP,
    input  logic [CHANNELS-1:0]       SCLR,
    input  logic [CHANNELS-1:0]       LOAD,
    input  logic [CHANNELS*WIDTH-1:0] D,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       TC
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic en_eff_s;
        logic tc_s;

        // In cascade mode a channel only counts when its lower neighbour is
        // at terminal count; the per-channel tc_s keeps the chain acyclic.
        if ((CASCADE != 0) && (i > 0)) begin : g_casc
            assign en_eff_s = EN[i] & g_chan[i-1].tc_s;
        end else begin : g_flat
            assign en_eff_s = EN[i];
        end

        mod_74x_counter_chan #(
            .WIDTH   (WIDTH),
            .MODULUS (MODULUS)
        ) u_chan (
            .clk    (CLK),
            .clr_n  (CLR_N),
            .en_eff (en_eff_s),
            .up     (UP[i]),
            .sclr   (SCLR[i]),
            .load   (LOAD[i]),
            .d      (D[i*WIDTH +: WIDTH]),
            .q      (Q[i*WIDTH +: WIDTH]),
            .tc     (tc_s)
        );

        assign TC[i] = tc_s;
    end

endmodule

// File: tb/tb_mod_74x_multi_counter.sv
// Self-checking bench for mod_74x_multi_counter. Three instances share one
// clock: default geometry (a), MODULUS=10 single channel (b) and a cascaded
// pair (c). A behavioural model tracks every channel as a plain integer and
// is compared each rising edge; directed literal checks pin the model.
module tb_mod_74x_multi_counter;

    logic clk = 1'b0;
    logic clr_n;

    logic [1:0] en_a, up_a, sclr_a, load_a;
    logic [7:0] d_a;
    logic [7:0] q_a;
    logic [1:0] tc_a;

    logic       en_b, up_b, sclr_b, load_b;
    logic [3:0] d_b;
    logic [3:0] q_b;
    logic       tc_b;

    logic [1:0] en_c, up_c, sclr_c, load_c;
    logic [7:0] d_c;
    logic [7:0] q_c;
    logic [1:0] tc_c;

    int checks = 0;
    int errors = 0;

    int ma [2] = '{0, 0};
    int mb     = 0;
    int mc [2] = '{0, 0};

    always #5 clk = ~clk;

    mod_74x_multi_counter #(.WIDTH(4), .CHANNELS(2), .MODULUS(16), .CASCADE(0)) u_a (
        .CLK(clk), .CLR_N(clr_n), .EN(en_a), .UP(up_a), .SCLR(sclr_a),
        .LOAD(load_a), .D(d_a), .Q(q_a), .TC(tc_a));

    mod_74x_multi_counter #(.WIDTH(4), .CHANNELS(1), .MODULUS(10), .CASCADE(0)) u_b (
        .CLK(clk), .CLR_N(clr_n), .EN(en_b), .UP(up_b), .SCLR(sclr_b),
        .LOAD(load_b), .D(d_b), .Q(q_b), .TC(tc_b));

    mod_74x_multi_counter #(.WIDTH(4), .CHANNELS(2), .MODULUS(16), .CASCADE(1)) u_c (
        .CLK(clk), .CLR_N(clr_n), .EN(en_c), .UP(up_c), .SCLR(sclr_c),
        .LOAD(load_c), .D(d_c), .Q(q_c), .TC(tc_c));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next value of one channel by the priority rules.
    function automatic int nxt(input int q, input bit en, input bit up,
                               input bit sclr, input bit load, input int d, input int m);
        if (sclr) return 0;
        if (load) return d;
        if (!en) return q;
        if (up) return (q >= m - 1) ? 0 : q + 1;
        return (q == 0) ? m - 1 : q - 1;
    endfunction

    function automatic bit tcf(input int q, input bit en, input bit up, input int m);
        return en && (up ? (q == m - 1) : (q == 0));
    endfunction

    // Effective enable of the cascaded instance, from the model state.
    function automatic bit eff_c(input int ch);
        if (ch == 0) return en_c[0];
        return en_c[1] && tcf(mc[0], en_c[0], up_c[0], 16);
    endfunction

    // Reference model: asynchronous clear, otherwise falling-edge update.
    always @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ma[0] <= 0;
            ma[1] <= 0;
            mb    <= 0;
            mc[0] <= 0;
            mc[1] <= 0;
        end else begin
            ma[0] <= nxt(ma[0], en_a[0], up_a[0], sclr_a[0], load_a[0], int'(d_a[3:0]), 16);
            ma[1] <= nxt(ma[1], en_a[1], up_a[1], sclr_a[1], load_a[1], int'(d_a[7:4]), 16);
            mb    <= nxt(mb, en_b, up_b, sclr_b, load_b, int'(d_b), 10);
            mc[0] <= nxt(mc[0], eff_c(0), up_c[0], sclr_c[0], load_c[0], int'(d_c[3:0]), 16);
            mc[1] <= nxt(mc[1], eff_c(1), up_c[1], sclr_c[1], load_c[1], int'(d_c[7:4]), 16);
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(posedge clk) begin
        check("q_a0", int'(q_a[3:0]), ma[0]);
        check("q_a1", int'(q_a[7:4]), ma[1]);
        check("tc_a0", int'(tc_a[0]), int'(tcf(ma[0], en_a[0], up_a[0], 16)));
        check("tc_a1", int'(tc_a[1]), int'(tcf(ma[1], en_a[1], up_a[1], 16)));
        check("q_b", int'(q_b), mb);
        check("tc_b", int'(tc_b), int'(tcf(mb, en_b, up_b, 10)));
        check("q_c0", int'(q_c[3:0]), mc[0]);
        check("q_c1", int'(q_c[7:4]), mc[1]);
        check("tc_c0", int'(tc_c[0]), int'(tcf(mc[0], eff_c(0), up_c[0], 16)));
        check("tc_c1", int'(tc_c[1]), int'(tcf(mc[1], eff_c(1), up_c[1], 16)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_n = 1'b1;
        en_a = 2'b00; up_a = 2'b00; sclr_a = 2'b00; load_a = 2'b00; d_a = 8'h00;
        en_b = 1'b0;  up_b = 1'b0;  sclr_b = 1'b0;  load_b = 1'b0;  d_b = 4'h0;
        en_c = 2'b00; up_c = 2'b00; sclr_c = 2'b00; load_c = 2'b00; d_c = 8'h00;
        #2 clr_n = 1'b0;
        tick();
        check("reset_q_a", int'(q_a), 0);
        check("reset_q_b", int'(q_b), 0);
        check("reset_q_c", int'(q_c), 0);

        // a counts up on both channels, b counts down mod 10, c cascades up.
        clr_n = 1'b1;
        en_a = 2'b11; up_a = 2'b11;
        en_b = 1'b1;  up_b = 1'b0;
        en_c = 2'b11; up_c = 2'b11;
        for (int t = 1; t <= 256; t++) begin
            tick();
            if (t == 1) begin
                check("up_first", int'(q_a[3:0]), 1);
                check("down_first", int'(q_b), 9);
                check("casc_first", int'(q_c), 8'h01);
            end
            if (t == 10) begin
                check("down_zero", int'(q_b), 0);
                check("down_zero_tc", int'(tc_b), 1);
            end
            if (t == 11) check("down_wrap", int'(q_b), 9);
            if (t == 15) begin
                check("up_max", int'(q_a[3:0]), 15);
                check("up_max_tc", int'(tc_a[0]), 1);
            end
            if (t == 16) begin
                check("up_wrap", int'(q_a[3:0]), 0);
                check("up_wrap_tc", int'(tc_a[0]), 0);
                check("casc_16", int'(q_c), 8'h10);
            end
            if (t == 255) begin
                check("casc_ff", int'(q_c), 8'hFF);
                check("casc_ff_tc1", int'(tc_c[1]), 1);
            end
            if (t == 256) begin
                check("casc_wrap", int'(q_c), 8'h00);
                check("casc_wrap_tc1", int'(tc_c[1]), 0);
            end
        end

        // Clear beats load on channel 1; channel 0 keeps counting.
        en_a = 2'b01; load_a = 2'b10; sclr_a = 2'b10; d_a = 8'hC0;
        tick();
        check("sclr_over_load", int'(q_a[7:4]), 0);
        check("ch0_indep_1", int'(q_a[3:0]), 1);
        sclr_a = 2'b00;
        tick();
        check("load_c", int'(q_a[7:4]), 12);
        check("ch0_indep_2", int'(q_a[3:0]), 2);
        load_a = 2'b00;

        // Hold at 3 with enable low.
        tick();
        check("reach_3", int'(q_a[3:0]), 3);
        en_a = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_q", int'(q_a[3:0]), 3);
            check("hold_tc", int'(tc_a[0]), 0);
        end

        // Asynchronous clear between edges at Q=7.
        en_a = 2'b01;
        repeat (4) tick();
        check("reach_7", int'(q_a[3:0]), 7);
        #1 clr_n = 1'b0;
        #1;
        check("async_clr_a", int'(q_a), 0);
        check("async_clr_c", int'(q_c), 0);
        check("clr_tc_down", int'(tc_b), 1);
        clr_n = 1'b1;
        tick();
        check("after_clr", int'(q_a[3:0]), 1);
        check("after_clr_ch1", int'(q_a[7:4]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
